// File: rtl/dbus_fabric.sv
// Single-master data bus fabric: decodes the master address onto one of NUM_SLAVES
// peripheral slots, waits for that slot's ack (bounded by a timeout) and returns a one-cycle response.
module dbus_fabric #(
    parameter int                            NUM_SLAVES  = 8,
    parameter int                            ADDR_W      = 32,
    parameter int                            DATA_W      = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_BASE    = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLV_MASK    = '0,
    parameter int                            TIMEOUT_CYC = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           m_req_i,
    input  logic [ADDR_W-1:0]              m_addr_i,
    input  logic                           m_we_i,
    input  logic [DATA_W/8-1:0]            m_be_i,
    input  logic [DATA_W-1:0]              m_wdata_i,
    input  logic                           m_flush_i,
    output logic                           m_ack_o,
    output logic                           m_err_o,
    output logic [DATA_W-1:0]              m_rdata_o,
    output logic [NUM_SLAVES-1:0]          s_sel_o,
    output logic [ADDR_W-1:0]              s_addr_o,
    output logic                           s_we_o,
    output logic [DATA_W/8-1:0]            s_be_o,
    output logic [DATA_W-1:0]              s_wdata_o,
    input  logic [NUM_SLAVES-1:0]          s_ack_i,
    input  logic [NUM_SLAVES*DATA_W-1:0]   s_rdata_i,
    output logic [ADDR_W-1:0]              err_addr_o
);

    localparam int          BE_W = DATA_W / 8;
    localparam logic [15:0] TMO  = 16'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  r_state, w_state_nx;
    logic [NUM_SLAVES-1:0]   r_sel, w_sel_nx;
    logic [ADDR_W-1:0]       r_addr, w_addr_nx;
    logic                    r_we, w_we_nx;
    logic [BE_W-1:0]         r_be, w_be_nx;
    logic [DATA_W-1:0]       r_wdata, w_wdata_nx;
    logic [15:0]             r_cnt, w_cnt_nx;
    logic                    r_ack, w_ack_nx;
    logic                    r_err, w_err_nx;
    logic [DATA_W-1:0]       r_rdata, w_rdata_nx;
    logic [ADDR_W-1:0]       r_err_addr, w_err_addr_nx;

    logic [NUM_SLAVES-1:0]   w_match;
    logic [NUM_SLAVES-1:0]   w_first;
    logic                    w_found;
    logic                    w_slv_ack;
    logic [DATA_W-1:0]       w_slv_rdata;

    // Address decode with lowest-index priority, plus ack/rdata gathered from the selected slot only
    always_comb begin
        w_match     = '0;
        w_first     = '0;
        w_found     = 1'b0;
        w_slv_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_match[i]  = ((m_addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]);
            w_first[i]  = w_match[i] & ~w_found;
            w_found     = w_found | w_match[i];
            w_slv_rdata = w_slv_rdata | (s_rdata_i[i*DATA_W +: DATA_W] & {DATA_W{r_sel[i]}});
        end
        w_slv_ack = |(s_ack_i & r_sel);
    end

    // Next-state and next-register values for the access sequencer
    always_comb begin
        w_state_nx    = r_state;
        w_sel_nx      = r_sel;
        w_addr_nx     = r_addr;
        w_we_nx       = r_we;
        w_be_nx       = r_be;
        w_wdata_nx    = r_wdata;
        w_cnt_nx      = r_cnt;
        w_ack_nx      = 1'b0;
        w_err_nx      = 1'b0;
        w_rdata_nx    = r_rdata;
        w_err_addr_nx = r_err_addr;
        case (r_state)
            IDLE: begin
                if (m_req_i && !m_flush_i) begin
                    if (w_found) begin
                        w_sel_nx   = w_first;
                        w_addr_nx  = m_addr_i;
                        w_we_nx    = m_we_i;
                        w_be_nx    = m_be_i;
                        w_wdata_nx = m_wdata_i;
                        w_cnt_nx   = 16'd1;
                        w_state_nx = ACCESS;
                    end else begin
                        w_err_nx      = 1'b1;
                        w_err_addr_nx = m_addr_i;
                        w_rdata_nx    = '0;
                        w_state_nx    = RESP;
                    end
                end else begin
                    w_state_nx = IDLE;
                end
            end
            ACCESS: begin
                // Abort wins over a same-cycle ack; ack wins over timeout
                if (m_flush_i) begin
                    w_sel_nx   = '0;
                    w_cnt_nx   = 16'd0;
                    w_state_nx = IDLE;
                end else if (w_slv_ack) begin
                    w_sel_nx   = '0;
                    w_cnt_nx   = 16'd0;
                    w_ack_nx   = 1'b1;
                    w_rdata_nx = r_we ? {DATA_W{1'b0}} : w_slv_rdata;
                    w_state_nx = RESP;
                end else if (r_cnt >= TMO) begin
                    w_sel_nx      = '0;
                    w_cnt_nx      = 16'd0;
                    w_err_nx      = 1'b1;
                    w_err_addr_nx = r_addr;
                    w_rdata_nx    = '0;
                    w_state_nx    = RESP;
                end else begin
                    w_cnt_nx = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
                end
            end
            RESP: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_sel_nx   = '0;
                w_cnt_nx   = 16'd0;
                w_state_nx = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_cnt      <= 16'd0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_err_addr <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_sel      <= w_sel_nx;
            r_addr     <= w_addr_nx;
            r_we       <= w_we_nx;
            r_be       <= w_be_nx;
            r_wdata    <= w_wdata_nx;
            r_cnt      <= w_cnt_nx;
            r_ack      <= w_ack_nx;
            r_err      <= w_err_nx;
            r_rdata    <= w_rdata_nx;
            r_err_addr <= w_err_addr_nx;
        end
    end

    assign m_ack_o    = r_ack;
    assign m_err_o    = r_err;
    assign m_rdata_o  = r_rdata;
    assign s_sel_o    = r_sel;
    assign s_addr_o   = r_addr;
    assign s_we_o     = r_we;
    assign s_be_o     = r_be;
    assign s_wdata_o  = r_wdata;
    assign err_addr_o = r_err_addr;

endmodule

// File: tb/tb_dbus_fabric.sv
// Table-driven bench for dbus_fabric: 4 slots (slots 1 and 3 overlap), timeout of 4 cycles,
// plus hand-written flush and asynchronous-reset sequences.
module tb_dbus_fabric;

    localparam int NS = 4;
    localparam logic [NS*32-1:0] BASE = {32'h3000_0010, 32'h2000_0000, 32'h3000_0000, 32'h1000_0000};
    localparam logic [NS*32-1:0] MASK = {32'hFFFF_FFF0, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};

    logic             clk = 1'b0;
    logic             rst;
    logic             m_req, m_we, m_flush;
    logic [31:0]      m_addr, m_wdata;
    logic [3:0]       m_be;
    logic             m_ack, m_err;
    logic [31:0]      m_rdata, s_addr, s_wdata, err_addr;
    logic [NS-1:0]    s_sel, s_ack;
    logic             s_we;
    logic [3:0]       s_be;
    logic [NS*32-1:0] s_rdata;

    int n_total = 0;
    int n_pass  = 0;

    dbus_fabric #(
        .NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT_CYC(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be),
        .m_wdata_i(m_wdata), .m_flush_i(m_flush),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_rdata_o(m_rdata),
        .s_sel_o(s_sel), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be),
        .s_wdata_o(s_wdata), .s_ack_i(s_ack), .s_rdata_i(s_rdata),
        .err_addr_o(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          ack_slot;
        int          ack_dly;
        logic [31:0] rval;
        logic [3:0]  exp_sel;
        logic        exp_ack;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                                input int ack_slot, input int ack_dly, input logic [31:0] rval,
                                input logic [3:0] exp_sel, input logic exp_ack, input int exp_lat,
                                input logic [31:0] exp_rdata, input logic [31:0] exp_eaddr);
        vec_t v;
        v.addr = addr; v.we = we; v.wdata = wdata; v.ack_slot = ack_slot; v.ack_dly = ack_dly;
        v.rval = rval; v.exp_sel = exp_sel; v.exp_ack = exp_ack; v.exp_lat = exp_lat;
        v.exp_rdata = exp_rdata; v.exp_eaddr = exp_eaddr;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit got;
        got     = 1'b0;
        m_req   = 1'b1;
        m_addr  = v.addr;
        m_we    = v.we;
        m_be    = v.we ? 4'h3 : 4'hF;
        m_wdata = v.wdata;
        s_ack   = '0;
        for (int k = 0; k < NS; k++) s_rdata[k*32 +: 32] = (k == v.ack_slot) ? v.rval : ~v.rval;
        for (int c = 1; c <= 20 && !got; c++) begin
            tick();
            chk($sformatf("v%0d_sel_c%0d", idx, c), 32'(s_sel), 32'((c < v.exp_lat) ? v.exp_sel : 4'h0));
            if (c == 1 && v.exp_sel != 4'h0) begin
                chk($sformatf("v%0d_s_addr", idx), s_addr, v.addr);
                chk($sformatf("v%0d_s_we", idx), 32'(s_we), 32'(v.we));
                chk($sformatf("v%0d_s_be", idx), 32'(s_be), 32'(v.we ? 4'h3 : 4'hF));
                chk($sformatf("v%0d_s_wdata", idx), s_wdata, v.wdata);
            end
            if (m_ack || m_err) begin
                got = 1'b1;
                chk($sformatf("v%0d_ack", idx), 32'(m_ack), 32'(v.exp_ack));
                chk($sformatf("v%0d_err", idx), 32'(m_err), 32'(!v.exp_ack));
                chk($sformatf("v%0d_lat", idx), 32'(c), 32'(v.exp_lat));
                chk($sformatf("v%0d_rdata", idx), m_rdata, v.exp_rdata);
                chk($sformatf("v%0d_err_addr", idx), err_addr, v.exp_eaddr);
                m_req = 1'b0;
                s_ack = '0;
            end else begin
                s_ack = '0;
                if (c >= 1 + v.ack_dly) s_ack[v.ack_slot] = 1'b1;
            end
        end
        if (!got) begin
            n_total++;
            $display("FAIL v%0d_no_response: got none expected response within 20 cycles", idx);
            m_req = 1'b0;
            s_ack = '0;
            repeat (6) tick();
        end
        tick();
        chk($sformatf("v%0d_ack_pulse_end", idx), 32'(m_ack), 32'd0);
        chk($sformatf("v%0d_err_pulse_end", idx), 32'(m_err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_flush = 1'b0;
        m_addr = '0; m_wdata = '0; m_be = '0; s_ack = '0; s_rdata = '0;

        //          addr          we    wdata         slot dly rval          sel   ack lat rdata         err_addr
        vecs[0] = mk(32'h2000_0004, 1'b0, 32'h0,        2,  0, 32'hDEAD_BEEF, 4'h4, 1'b1, 2, 32'hDEAD_BEEF, 32'h0);
        vecs[1] = mk(32'hF000_0000, 1'b1, 32'h1111_2222, 0, 0, 32'h0,         4'h0, 1'b0, 1, 32'h0,         32'hF000_0000);
        vecs[2] = mk(32'h1000_0000, 1'b0, 32'h0,        0,  2, 32'h1234_5678, 4'h1, 1'b1, 4, 32'h1234_5678, 32'hF000_0000);
        vecs[3] = mk(32'h2000_0010, 1'b1, 32'h5555_AAAA, 2, 1, 32'h7777_7777, 4'h4, 1'b1, 3, 32'h0,         32'hF000_0000);
        vecs[4] = mk(32'h3000_0010, 1'b0, 32'h0,        1,  0, 32'hA5A5_5A5A, 4'h2, 1'b1, 2, 32'hA5A5_5A5A, 32'hF000_0000);
        vecs[5] = mk(32'h1000_0040, 1'b0, 32'h0,        3,  0, 32'h9999_9999, 4'h1, 1'b0, 5, 32'h0,         32'h1000_0040);
        vecs[6] = mk(32'h2000_0008, 1'b0, 32'h0,        2,  3, 32'hCAFE_F00D, 4'h4, 1'b1, 5, 32'hCAFE_F00D, 32'h1000_0040);
        vecs[7] = mk(32'h3000_0020, 1'b1, 32'hFEED_0001, 1, 0, 32'h4444_4444, 4'h2, 1'b1, 2, 32'h0,         32'h1000_0040);
        vecs[8] = mk(32'h2000_0000, 1'b0, 32'h0,        2,  0, 32'h0BAD_F00D, 4'h4, 1'b1, 2, 32'h0BAD_F00D, 32'h1000_0040);

        tick(); tick();
        chk("rst_sel", 32'(s_sel), 32'd0);
        chk("rst_ack", 32'(m_ack), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        #2 rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Flush during ACCESS beats a same-cycle ack; rdata holds its previous value
        m_req = 1'b1; m_addr = 32'h2000_0000; m_we = 1'b0; m_be = 4'hF;
        tick();
        chk("fl_sel_access", 32'(s_sel), 32'h4);
        m_flush = 1'b1; m_req = 1'b0; s_ack = 4'h4;
        tick();
        chk("fl_sel_clear", 32'(s_sel), 32'd0);
        chk("fl_ack", 32'(m_ack), 32'd0);
        chk("fl_err", 32'(m_err), 32'd0);
        m_flush = 1'b0; s_ack = '0;
        tick();
        chk("fl_ack2", 32'(m_ack), 32'd0);
        chk("fl_err2", 32'(m_err), 32'd0);
        chk("fl_rdata_hold", m_rdata, 32'h0BAD_F00D);

        // Flush in IDLE discards an unmapped request outright
        m_req = 1'b1; m_flush = 1'b1; m_addr = 32'hF000_0000;
        tick();
        chk("fli_err", 32'(m_err), 32'd0);
        chk("fli_sel", 32'(s_sel), 32'd0);
        m_req = 1'b0; m_flush = 1'b0;
        tick();
        chk("fli_err2", 32'(m_err), 32'd0);
        chk("fli_err_addr", err_addr, 32'h1000_0040);

        // Asynchronous reset in the middle of an access
        m_req = 1'b1; m_addr = 32'h2000_0000; m_we = 1'b0;
        tick();
        chk("ra_sel_access", 32'(s_sel), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("ra_sel", 32'(s_sel), 32'd0);
        chk("ra_rdata", m_rdata, 32'd0);
        chk("ra_err_addr", err_addr, 32'd0);
        chk("ra_s_addr", s_addr, 32'd0);
        m_req = 1'b0;
        tick();
        #2 rst = 1'b0;
        tick();
        chk("ra_ack", 32'(m_ack), 32'd0);
        chk("ra_err", 32'(m_err), 32'd0);
        chk("ra_sel_after", 32'(s_sel), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dbus_fabric.md
DBUS_FABRIC -- requirements
Module: dbus_fabric

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 8, number of peripheral slots (1..16).
REQ-002 SHALL have parameter ADDR_W, default 32, bus address width.
REQ-003 SHALL have parameter DATA_W, default 32, bus data width.
REQ-004 SHALL have parameter SLV_BASE, default all-zero, packed NUM_SLAVES x ADDR_W base-address table.
REQ-005 SHALL have parameter SLV_MASK, default all-zero, packed NUM_SLAVES x ADDR_W address masks; slot i matches when (addr & SLV_MASK[i]) == SLV_BASE[i].
REQ-006 SHALL have parameter TIMEOUT_CYC, default 255, maximum cycles to wait for a slave ack (1..65535).
REQ-007 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port m_req_i  input  1  master request valid, held until m_ack_o or m_err_o.
REQ-010 SHALL have port m_addr_i  input  ADDR_W  master address.
REQ-011 SHALL have port m_we_i  input  1  1 = write, 0 = read.
REQ-012 SHALL have port m_be_i  input  DATA_W/8  byte enables.
REQ-013 SHALL have port m_wdata_i  input  DATA_W  write data.
REQ-014 SHALL have port m_flush_i  input  1  abort any in-flight access.
REQ-015 SHALL have port m_ack_o  output  1  one-cycle completion pulse.
REQ-016 SHALL have port m_err_o  output  1  one-cycle bus-error pulse (unmapped or timeout).
REQ-017 SHALL have port m_rdata_o  output  DATA_W  read data, valid with m_ack_o.
REQ-018 SHALL have port s_sel_o  output  NUM_SLAVES  one-hot slave select.
REQ-019 SHALL have port s_addr_o, s_we_o, s_be_o, s_wdata_o  output  as master  registered copies broadcast to all slaves.
REQ-020 SHALL have port s_ack_i  input  NUM_SLAVES  per-slave completion.
REQ-021 SHALL have port s_rdata_i  input  NUM_SLAVES x DATA_W  per-slave read data.
REQ-022 SHALL have port err_addr_o  output  ADDR_W  address of the last errored access.

Function
REQ-023 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-024 SHALL, in IDLE with m_req_i=1 and a matching slot, register address/we/be/wdata, assert s_sel_o of that slot from the next cycle, and enter ACCESS.
REQ-025 SHALL resolve multiple matching slots to the lowest index.
REQ-026 SHALL, in IDLE with m_req_i=1 and no matching slot, drive no s_sel_o, capture err_addr_o, pulse m_err_o the next cycle, and enter RESP.
REQ-027 SHALL, in ACCESS, keep s_sel_o and the registered payload stable and count cycles from 1.
REQ-028 SHALL, in ACCESS when the selected slave's s_ack_i=1, register its s_rdata_i into m_rdata_o, pulse m_ack_o the next cycle, clear s_sel_o, and enter RESP.
REQ-029 SHALL ignore s_ack_i of unselected slots.
REQ-030 SHALL, when the counter reaches TIMEOUT_CYC without ack, clear s_sel_o, capture err_addr_o, pulse m_err_o the next cycle, and enter RESP.
REQ-031 SHALL give ack priority over timeout when both occur in the same cycle.
REQ-032 SHALL spend exactly one cycle in RESP (the m_ack_o/m_err_o pulse) then return to IDLE; a new request is accepted only from IDLE.
REQ-033 SHALL yield minimum latency: request in IDLE at cycle 0, slave ack at cycle 1, m_ack_o at cycle 2.
REQ-034 SHALL, on m_flush_i=1 in ACCESS, clear s_sel_o next cycle, return to IDLE, and produce neither m_ack_o nor m_err_o; in IDLE the same-cycle request is discarded.
REQ-035 SHALL hold m_rdata_o until the next ack; m_rdata_o SHALL be zero for writes and errors.
REQ-036 SHALL saturate the timeout counter at 16 bits.

Reset
REQ-037 SHALL, on rst=1 (immediately, independent of clk), force IDLE, s_sel_o=0, m_ack_o=0, m_err_o=0, m_rdata_o=0, err_addr_o=0, counter=0, payload registers=0; an access in progress is dropped without response.

Verification
REQ-038 Read slot 2 (SLV_BASE=0x2000_0000, MASK=0xFF00_0000), slave acks cycle 1 with 0xDEAD_BEEF -> m_ack_o cycle 2, m_rdata_o=0xDEAD_BEEF, s_sel_o=0b100 cycle 1 only.
REQ-039 Write to 0xF000_0000 (unmapped) -> s_sel_o stays 0, m_err_o cycle 1, err_addr_o=0xF000_0000.
REQ-040 TIMEOUT_CYC=4, slave never acks -> m_err_o exactly one cycle after counter reaches 4, s_sel_o cleared, FSM IDLE next cycle.
REQ-041 Slave ack and counter=TIMEOUT_CYC in same cycle -> m_ack_o only, no m_err_o.
REQ-042 m_flush_i during ACCESS, then rst asserted mid-access on a second request -> no ack/err in either case, all outputs zero immediately on rst.
REQ-043 Overlapping slots 1 and 3 both match 0x3000_0010 -> s_sel_o=0b0010.
